axi4_mem_responder: RTL and testbench
=====================================

AXI4_MEM_RESPONDER -- requirements
Module: axi4_mem_responder

Interface
REQ-001 Parameters, one per line: ADDR_WIDTH, 32, address bits; DATA_WIDTH, 32, data bits (32 or 64); ID_WIDTH, 4, ID bits; MEM_DEPTH, 256, memory words.
REQ-002 Port: clk, input, 1, single clock; all logic is on its rising edge.
REQ-003 Port: resetn, input, 1, reset; asynchronous, active-low.
REQ-004 Ports: awid/awaddr/awlen[8]/awsize[3]/awburst[2], awvalid, input; awready, output; write address channel.
REQ-005 Ports: wdata/wstrb[DATA_WIDTH/8]/wlast, wvalid, input; wready, output; write data channel.
REQ-006 Ports: bid/bresp[2], bvalid, output; bready, input; write response channel.
REQ-007 Ports: arid/araddr/arlen[8]/arsize[3]/arburst[2], arvalid, input; arready, output; read address channel.
REQ-008 Ports: rid/rdata/rresp[2]/rlast, rvalid, output; rready, input; read data channel.

Function
REQ-009 A transfer occurs on a rising edge with valid and ready both high; once asserted, an output valid and its payload stay stable until that transfer completes.
REQ-010 The write and read paths are independent; each path has one outstanding transaction.
REQ-011 Write FSM states: W_IDLE, with awready=1, to W_DATA on AW transfer; W_DATA, with wready=1, to W_RESP after beat awlen+1; W_RESP, with bvalid=1, to W_IDLE on B transfer.
REQ-012 Read FSM states: R_IDLE, with arready=1, to R_DATA on AR transfer; R_DATA, with rvalid=1, to R_IDLE on the transfer with rlast=1.
REQ-013 Latency is fixed: bvalid rises 1 cycle after the last W transfer; first rvalid is 1 cycle after the AR transfer; each subsequent beat is valid 1 cycle after the previous R transfer; awready and arready reassert 1 cycle after their FSM returns to idle.
REQ-014 Word index is addr >> log2(DATA_WIDTH/8).
REQ-015 FIXED burst: every beat uses the same word index; INCR burst: the index increments by 1 per beat.
REQ-016 A beat is in error when its word index is >= MEM_DEPTH; the index is checked per beat and never wraps.
REQ-017 A transaction returns SLVERR when any of these holds: burst is WRAP or reserved; size != log2(DATA_WIDTH/8); any beat is in error; wlast is not high on exactly beat awlen+1.
REQ-018 Write beats: each lane with wstrb set is written unless the whole transaction is SLVERR-qualified by burst, size or range, in which case no byte is written.
REQ-019 bresp for a write is the OR of all error conditions, giving OKAY (00) or SLVERR (10).
REQ-020 Read beats: an error beat returns rdata=0 with rresp=SLVERR; other beats return stored data with rresp=OKAY.
REQ-021 rlast=1 only on beat arlen+1.
REQ-022 bid and rid return the ID captured at address acceptance.
REQ-023 A same-word read and write on the same edge returns the old data to the read.
REQ-024 awlen=0 and arlen=0 are single-beat transfers.
REQ-025 Back-pressure of any length on bready or rready stalls only its own path.

Reset
REQ-026 While resetn=0: both FSMs are idle, the beat counters are 0, and all outputs are 0, including awready and arready.
REQ-027 awready and arready rise on the first clk edge after resetn deasserts.
REQ-028 A reset asserted mid-transaction abandons that transaction with no response; bytes already written are kept.
REQ-029 The memory array is not reset.

Structure
REQ-030 Package axi4_resp_pkg holds the burst_t enum (FIXED/INCR/WRAP), the resp_t enum (OKAY/SLVERR), and the wr_state_t and rd_state_t typedefs.
REQ-031 Sub-module axi4_beat_addr computes the next word index and the per-beat error flag from base, burst, size and beat count; it is instantiated once per path.

Verification
REQ-032 Write AW(id=3, addr=0x10, len=3, INCR, size=2), W 0xA0..0xA3 with wstrb=F -> B(id=3, OKAY); a read of the same range returns 0xA0..0xA3 with rlast on beat 4 only.
REQ-033 FIXED write len=1 to 0x20 with data 0x11 then 0x22 -> word 8 holds 0x22; wstrb=0x1 on 0xFFFFFFFF writes byte 0 only.
REQ-034 INCR read addr=0x3F8, len=3, MEM_DEPTH=256 -> beats 1-2 OKAY with data, beats 3-4 SLVERR with rdata=0.
REQ-035 WRAP write, or size=1 -> bresp=SLVERR and memory unchanged.
REQ-036 Concurrent traffic: rready low for 5 cycles during a read while a write completes -> write B occurs with no stall and the read data stays stable.
REQ-037 Reset mid-burst (resetn low at beat 2 of 4) -> all valids 0 and awready=1 on the first edge after release; a subsequent transaction completes normally.

Source files
------------

// File: rtl/axi4_resp_pkg.sv
// Shared types for the AXI4 memory responder.
// Burst/response encodings and the two path FSM state types.
package axi4_resp_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4_mem_responder_if.sv
// AXI4 bus bundle between a master and the memory responder.
// Five channels; clock and reset stay outside the bundle.
interface axi4_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize,
    input  awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize,
    input  arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize,
    output awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize,
    output arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi4_beat_addr.sv
// Word index and error flag for one beat of a burst.
// Index is one bit wider than the address so it never wraps.
module axi4_beat_addr
  import axi4_resp_pkg::*;
#(
  parameter int  ADDR_WIDTH = 32,
  parameter int  DATA_WIDTH = 32,
  parameter int  MEM_DEPTH  = 256,
  localparam int MW = $clog2(MEM_DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [1:0]            burst,
  input  logic [2:0]            size,
  input  logic [7:0]            beat,
  output logic [MW-1:0]         word,
  output logic                  err
);

  localparam int SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int IW    = ADDR_WIDTH + 1;

  logic [IW-1:0] idx;
  logic [IW-1:0] step;
  logic          burst_ok;
  logic          size_ok;

  assign step = (burst == INCR) ? IW'(beat) : '0;
  assign idx  = IW'(base >> SHIFT) + step;

  assign burst_ok = (burst == FIXED) ||
                    (burst == INCR);
  assign size_ok  = (size == 3'(SHIFT));

  assign word = idx[MW-1:0];
  assign err  = (idx >= IW'(MEM_DEPTH)) ||
                !burst_ok || !size_ok;

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by a word-addressed memory array.
// Independent write and read paths, one transaction each.
module axi4_mem_responder
  import axi4_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input logic clk,
  input logic resetn,
  axi4_mem_responder_if.slave bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int MW = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  live;

  wr_state_t             wr_q, wr_d;
  logic [ID_WIDTH-1:0]   wid_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            wlen_q, wbeat_q;
  logic [1:0]            wburst_q;
  logic [2:0]            wsize_q;
  logic                  wsup_q, wlerr_q;
  logic [ADDR_WIDTH-1:0] wa_base;
  logic [1:0]            wa_burst;
  logic [2:0]            wa_size;
  logic [7:0]            wa_beat;
  logic [MW-1:0]         wa_word;
  logic                  wa_err;
  logic                  aw_hs, w_hs, b_hs, w_end;

  assign aw_hs = live && (wr_q == W_IDLE)
                 && bus.awvalid;
  assign w_hs  = (wr_q == W_DATA) && bus.wvalid;
  assign b_hs  = (wr_q == W_RESP) && bus.bready;
  assign w_end = (wbeat_q == wlen_q);

  // Idle probes the final beat so a range fault is known up front.
  always_comb begin
    wa_base  = waddr_q;
    wa_burst = wburst_q;
    wa_size  = wsize_q;
    wa_beat  = wbeat_q;
    if (wr_q == W_IDLE) begin
      wa_base  = bus.awaddr;
      wa_burst = bus.awburst;
      wa_size  = bus.awsize;
      wa_beat  = bus.awlen;
    end
  end

  axi4_beat_addr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_wr_addr (
    .base (wa_base),
    .burst(wa_burst),
    .size (wa_size),
    .beat (wa_beat),
    .word (wa_word),
    .err  (wa_err)
  );

  always_comb begin
    wr_d = wr_q;
    unique case (wr_q)
      W_IDLE: if (aw_hs) wr_d = W_DATA;
      W_DATA: if (w_hs && w_end) wr_d = W_RESP;
      W_RESP: if (b_hs) wr_d = W_IDLE;
      default: wr_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live     <= 1'b0;
      wr_q     <= W_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wbeat_q  <= '0;
      wburst_q <= '0;
      wsize_q  <= '0;
      wsup_q   <= 1'b0;
      wlerr_q  <= 1'b0;
    end else begin
      live <= 1'b1;
      wr_q <= wr_d;
      if (aw_hs) begin
        wid_q    <= bus.awid;
        waddr_q  <= bus.awaddr;
        wlen_q   <= bus.awlen;
        wburst_q <= bus.awburst;
        wsize_q  <= bus.awsize;
        wbeat_q  <= '0;
        wsup_q   <= wa_err;
        wlerr_q  <= 1'b0;
      end
      if (w_hs) begin
        wbeat_q <= wbeat_q + 8'd1;
        if (bus.wlast != w_end) wlerr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !wsup_q) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wstrb[i])
          mem[wa_word][8*i +: 8] <=
            bus.wdata[8*i +: 8];
      end
    end
  end

  assign bus.awready = live && (wr_q == W_IDLE);
  assign bus.wready  = (wr_q == W_DATA);
  assign bus.bvalid  = (wr_q == W_RESP);
  assign bus.bid     = wid_q;
  assign bus.bresp   = (wsup_q || wlerr_q) ?
                       SLVERR : OKAY;

  rd_state_t             rd_q, rd_d;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [7:0]            rlen_q, rbeat_q;
  logic [1:0]            rburst_q;
  logic [2:0]            rsize_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;
  logic [ADDR_WIDTH-1:0] ra_base;
  logic [1:0]            ra_burst;
  logic [2:0]            ra_size;
  logic [7:0]            ra_beat;
  logic [MW-1:0]         ra_word;
  logic                  ra_err;
  logic                  ar_hs, r_hs, r_load;

  assign ar_hs  = live && (rd_q == R_IDLE)
                  && bus.arvalid;
  assign r_hs   = (rd_q == R_DATA) && bus.rready;
  assign r_load = ar_hs || (r_hs && !rlast_q);

  // Prefetch the beat that will be presented after this edge.
  always_comb begin
    ra_base  = raddr_q;
    ra_burst = rburst_q;
    ra_size  = rsize_q;
    ra_beat  = rbeat_q + 8'd1;
    if (rd_q == R_IDLE) begin
      ra_base  = bus.araddr;
      ra_burst = bus.arburst;
      ra_size  = bus.arsize;
      ra_beat  = 8'd0;
    end
  end

  axi4_beat_addr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_rd_addr (
    .base (ra_base),
    .burst(ra_burst),
    .size (ra_size),
    .beat (ra_beat),
    .word (ra_word),
    .err  (ra_err)
  );

  always_comb begin
    rd_d = rd_q;
    unique case (rd_q)
      R_IDLE: if (ar_hs) rd_d = R_DATA;
      R_DATA: if (r_hs && rlast_q) rd_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q     <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rbeat_q  <= '0;
      rburst_q <= '0;
      rsize_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      rd_q <= rd_d;
      if (ar_hs) begin
        rid_q    <= bus.arid;
        raddr_q  <= bus.araddr;
        rlen_q   <= bus.arlen;
        rburst_q <= bus.arburst;
        rsize_q  <= bus.arsize;
        rbeat_q  <= '0;
        rlast_q  <= (bus.arlen == 8'd0);
      end else if (r_hs && !rlast_q) begin
        rbeat_q <= rbeat_q + 8'd1;
        rlast_q <= (rbeat_q + 8'd1 == rlen_q);
      end
      if (r_load) begin
        rdata_q <= ra_err ? '0 : mem[ra_word];
        rresp_q <= ra_err ? SLVERR : OKAY;
      end
    end
  end

  assign bus.arready = live && (rd_q == R_IDLE);
  assign bus.rvalid  = (rd_q == R_DATA);
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Bench for axi4_mem_responder: vector table, scoreboards
// for B and R, plus reset and back-pressure sequences.
module tb_axi4_mem_responder;

  localparam logic [1:0] BF = 2'd0;
  localparam logic [1:0] BI = 2'd1;
  localparam logic [1:0] BW = 2'd2;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi4_mem_responder_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)
  ) bus ();

  axi4_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .ID_WIDTH(4), .MEM_DEPTH(256)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] d0;
    logic [31:0] dinc;
    bit          badlast;
    logic [1:0]  resp;
  } vec_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  vec_t   vt[$];
  logic [31:0] mm [256];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    b_exp_t be;
    r_exp_t re;
    if (bus.bvalid && bus.bready) begin
      if (bq.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected bid=%0h",
                 bus.bid);
      end else begin
        be = bq.pop_front();
        chk("bid", bus.bid, be.id);
        chk("bresp", bus.bresp, be.resp);
      end
    end
    if (bus.rvalid && bus.rready) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL r_unexpected rid=%0h",
                 bus.rid);
      end else begin
        re = rq.pop_front();
        chk("rid", bus.rid, re.id);
        chk("rdata", bus.rdata, re.data);
        chk("rresp", bus.rresp, re.resp);
        chk("rlast", bus.rlast, re.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(
    bit wr, logic [3:0] id, logic [31:0] addr,
    logic [7:0] len, logic [1:0] burst,
    logic [2:0] size, logic [3:0] strb,
    logic [31:0] d0, logic [31:0] dinc,
    bit badlast, logic [1:0] resp);
    vec_t v;
    v.wr = wr; v.id = id; v.addr = addr;
    v.len = len; v.burst = burst; v.size = size;
    v.strb = strb; v.d0 = d0; v.dinc = dinc;
    v.badlast = badlast; v.resp = resp;
    return v;
  endfunction

  task automatic send_aw(input logic [3:0] id,
    input logic [31:0] a, input logic [7:0] l,
    input logic [1:0] b, input logic [2:0] s);
    int n = 0;
    bus.awid = id; bus.awaddr = a; bus.awlen = l;
    bus.awburst = b; bus.awsize = s;
    bus.awvalid = 1'b1;
    @(negedge clk);
    while (!bus.awready && n < 50) begin
      @(negedge clk); n++;
    end
    chk("aw_accept", bus.awready, 1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d,
    input logic [3:0] st, input logic lst);
    int n = 0;
    bus.wdata = d; bus.wstrb = st; bus.wlast = lst;
    bus.wvalid = 1'b1;
    @(negedge clk);
    while (!bus.wready && n < 50) begin
      @(negedge clk); n++;
    end
    chk("w_accept", bus.wready, 1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id,
    input logic [31:0] a, input logic [7:0] l,
    input logic [1:0] b, input logic [2:0] s);
    int n = 0;
    bus.arid = id; bus.araddr = a; bus.arlen = l;
    bus.arburst = b; bus.arsize = s;
    bus.arvalid = 1'b1;
    @(negedge clk);
    while (!bus.arready && n < 50) begin
      @(negedge clk); n++;
    end
    chk("ar_accept", bus.arready, 1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_b(input int lim);
    int n = 0;
    while (bq.size() != 0 && n < lim) begin
      @(negedge clk); n++;
    end
    chk("b_done", bq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_r(input int lim);
    int n = 0;
    while (rq.size() != 0 && n < lim) begin
      @(negedge clk); n++;
    end
    chk("r_done", rq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic model_write(input vec_t v);
    int li, idx;
    logic [31:0] d;
    li = int'(v.addr >> 2) +
         ((v.burst == BI) ? int'(v.len) : 0);
    if (v.burst < 2'd2 && v.size == 3'd2 &&
        li < 256) begin
      for (int k = 0; k <= int'(v.len); k++) begin
        idx = int'(v.addr >> 2) +
              ((v.burst == BI) ? k : 0);
        d = v.d0 + 32'(k) * v.dinc;
        for (int j = 0; j < 4; j++)
          if (v.strb[j]) mm[idx][8*j +: 8] = d[8*j +: 8];
      end
    end
  endtask

  task automatic push_reads(input vec_t v);
    int idx;
    r_exp_t re;
    for (int k = 0; k <= int'(v.len); k++) begin
      idx = int'(v.addr >> 2) +
            ((v.burst == BI) ? k : 0);
      re.id = v.id;
      re.last = (k == int'(v.len));
      if (v.burst < 2'd2 && v.size == 3'd2 &&
          idx < 256) begin
        re.data = mm[idx]; re.resp = OK;
      end else begin
        re.data = '0; re.resp = SE;
      end
      rq.push_back(re);
    end
  endtask

  task automatic run_vec(input vec_t v);
    b_exp_t be;
    logic lst;
    if (v.wr) begin
      be.id = v.id; be.resp = v.resp;
      bq.push_back(be);
      send_aw(v.id, v.addr, v.len, v.burst, v.size);
      for (int k = 0; k <= int'(v.len); k++) begin
        lst = v.badlast ? (k == 0) :
                          (k == int'(v.len));
        send_w(v.d0 + 32'(k) * v.dinc, v.strb, lst);
      end
      model_write(v);
      wait_b(50);
    end else begin
      push_reads(v);
      send_ar(v.id, v.addr, v.len, v.burst, v.size);
      wait_r(50);
    end
  endtask

  initial begin
    b_exp_t be;
    vec_t v;

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
    bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", bus.awready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_bid", bus.bid, 0);
    chk("rst_rid", bus.rid, 0);
    #2 resetn = 1'b1;
    #1 chk("awready_pre_edge", bus.awready, 0);
    @(posedge clk); #1;
    chk("awready_post", bus.awready, 1);
    chk("arready_post", bus.arready, 1);

    vt.push_back(mkv(1, 3, 32'h10, 3, BI, 2, 4'hF,
                     32'hA0, 1, 0, OK));
    vt.push_back(mkv(0, 5, 32'h10, 3, BI, 2, 0,
                     0, 0, 0, OK));
    vt.push_back(mkv(1, 1, 32'h20, 1, BF, 2, 4'hF,
                     32'h11, 32'h11, 0, OK));
    vt.push_back(mkv(0, 2, 32'h20, 0, BI, 2, 0,
                     0, 0, 0, OK));
    vt.push_back(mkv(1, 4, 32'h20, 0, BI, 2, 4'h1,
                     32'hFFFFFFFF, 0, 0, OK));
    vt.push_back(mkv(0, 4, 32'h20, 0, BI, 2, 0,
                     0, 0, 0, OK));
    vt.push_back(mkv(1, 6, 32'h3F8, 1, BI, 2, 4'hF,
                     32'h55, 1, 0, OK));
    vt.push_back(mkv(0, 6, 32'h3F8, 3, BI, 2, 0,
                     0, 0, 0, OK));
    vt.push_back(mkv(1, 8, 32'h10, 3, BW, 2, 4'hF,
                     32'hDEAD0000, 1, 0, SE));
    vt.push_back(mkv(1, 9, 32'h14, 0, BI, 1, 4'hF,
                     32'hBEEF, 0, 0, SE));
    vt.push_back(mkv(0, 5, 32'h10, 3, BI, 2, 0,
                     0, 0, 0, OK));
    vt.push_back(mkv(1, 12, 32'h400, 0, BF, 2, 4'hF,
                     32'h12345678, 0, 0, SE));
    vt.push_back(mkv(1, 13, 32'h3FC, 1, BI, 2, 4'hF,
                     32'hCAFE0000, 1, 0, SE));
    vt.push_back(mkv(0, 14, 32'h3F8, 1, BI, 2, 0,
                     0, 0, 0, OK));
    vt.push_back(mkv(0, 15, 32'h14, 2, BF, 2, 0,
                     0, 0, 0, OK));
    vt.push_back(mkv(1, 11, 32'h60, 1, BI, 2, 4'hF,
                     32'h31, 1, 1, SE));
    vt.push_back(mkv(0, 1, 32'h60, 1, BI, 2, 0,
                     0, 0, 0, OK));
    vt.push_back(mkv(1, 7, 32'h20, 0, BI, 2, 4'h6,
                     32'h12345678, 0, 0, OK));
    vt.push_back(mkv(0, 7, 32'h20, 0, BI, 2, 0,
                     0, 0, 0, OK));

    for (int i = 0; i < vt.size(); i++)
      run_vec(vt[i]);

    // Read held off by rready while a write completes.
    bus.rready = 1'b0;
    v = mkv(0, 7, 32'h10, 3, BI, 2, 0, 0, 0, 0, OK);
    push_reads(v);
    send_ar(7, 32'h10, 3, BI, 2);
    be.id = 9; be.resp = OK;
    bq.push_back(be);
    v = mkv(1, 9, 32'h80, 1, BI, 2, 4'hF,
            32'h12340000, 1, 0, OK);
    send_aw(9, 32'h80, 1, BI, 2);
    send_w(32'h12340000, 4'hF, 1'b0);
    send_w(32'h12340001, 4'hF, 1'b1);
    model_write(v);
    wait_b(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rvalid", bus.rvalid, 1);
      chk("stall_rdata", bus.rdata, 32'hA0);
      chk("stall_rlast", bus.rlast, 0);
    end
    chk("stall_rq", rq.size(), 4);
    bus.rready = 1'b1;
    wait_r(50);

    // B held off; read path must stay available.
    bus.bready = 1'b0;
    be.id = 10; be.resp = OK;
    bq.push_back(be);
    v = mkv(1, 10, 32'h84, 0, BI, 2, 4'hF,
            32'h0BADF00D, 0, 0, OK);
    send_aw(10, 32'h84, 0, BI, 2);
    send_w(32'h0BADF00D, 4'hF, 1'b1);
    model_write(v);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bstall_bvalid", bus.bvalid, 1);
      chk("bstall_bid", bus.bid, 10);
      chk("bstall_arready", bus.arready, 1);
    end
    bus.bready = 1'b1;
    wait_b(50);
    v = mkv(0, 3, 32'h80, 1, BI, 2, 0, 0, 0, 0, OK);
    run_vec(v);

    // Reset while beat 2 of 4 is on the bus.
    be.id = 2; be.resp = OK;
    bq.push_back(be);
    send_aw(2, 32'h40, 3, BI, 2);
    send_w(32'h71, 4'hF, 1'b0);
    mm[16] = 32'h71;
    bus.wdata = 32'h72; bus.wlast = 1'b0;
    bus.wvalid = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    bq.delete();
    #1;
    chk("mid_wready", bus.wready, 0);
    chk("mid_bvalid", bus.bvalid, 0);
    chk("mid_rvalid", bus.rvalid, 0);
    chk("mid_awready", bus.awready, 0);
    bus.wvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rel_awready", bus.awready, 1);
    chk("rel_arready", bus.arready, 1);
    chk("rel_bvalid", bus.bvalid, 0);
    chk("rel_wready", bus.wready, 0);
    run_vec(mkv(1, 10, 32'h44, 0, BI, 2, 4'hF,
                32'h99, 0, 0, OK));
    run_vec(mkv(0, 12, 32'h40, 1, BI, 2, 0,
                0, 0, 0, OK));

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
